// File: rtl/count_cmd_arbiter.sv
// Round-robin arbiter folding four one-cycle count requests onto one shared 16-bit counter.
// Define COUNT_SAT_EN to clamp updates at 0x0000/0xFFFF and flag clamps on sat.
module count_cmd_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [15:0] sw,
    input  logic        hold,
    output logic [15:0] count,
    output logic [3:0]  grant,
    output logic [3:0]  pend,
    output logic        drop,
    output logic        sat
);

    logic [3:0]  pend_q, pend_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [15:0] count_q, count_d;
    logic        drop_q, drop_d;
    logic [1:0]  gidx;
    logic [1:0]  idx;
    logic        found;
    logic [15:0] opnd;
    logic        is_add;
`ifdef COUNT_SAT_EN
    logic        sat_q, sat_d;
    logic [16:0] wide;
`endif

    // Search from ptr upward (mod 4); first pending index wins unless held.
    always_comb begin
        grant = '0;
        gidx  = '0;
        idx   = '0;
        found = 1'b0;
        if (!hold) begin
            for (int k = 0; k < 4; k++) begin
                idx = ptr_q + 2'(k);
                if (!found && pend_q[idx]) begin
                    found = 1'b1;
                    gidx  = idx;
                end
            end
        end
        if (found) begin
            grant[gidx] = 1'b1;
        end
    end

    always_comb begin
        pend_d  = req | (pend_q & ~grant);
        drop_d  = drop_q | (|(req & pend_q & ~grant));
        ptr_d   = found ? gidx + 2'd1 : ptr_q;
        opnd    = gidx[1] ? sw : 16'd1;
        is_add  = (gidx == 2'd0) || (gidx == 2'd3);
        count_d = count_q;
`ifdef COUNT_SAT_EN
        sat_d   = sat_q;
        wide    = is_add ? {1'b0, count_q} + {1'b0, opnd} : {1'b0, count_q} - {1'b0, opnd};
        if (found) begin
            // Bit 16 is carry on add and borrow on subtract.
            if (wide[16]) begin
                count_d = is_add ? 16'hFFFF : 16'h0000;
                sat_d   = 1'b1;
            end else begin
                count_d = wide[15:0];
            end
        end
`else
        if (found) begin
            count_d = is_add ? count_q + opnd : count_q - opnd;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q  <= '0;
            ptr_q   <= '0;
            count_q <= '0;
            drop_q  <= 1'b0;
`ifdef COUNT_SAT_EN
            sat_q   <= 1'b0;
`endif
        end else begin
            pend_q  <= pend_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            drop_q  <= drop_d;
`ifdef COUNT_SAT_EN
            sat_q   <= sat_d;
`endif
        end
    end

    assign count = count_q;
    assign pend  = pend_q;
    assign drop  = drop_q;
`ifdef COUNT_SAT_EN
    assign sat   = sat_q;
`else
    assign sat   = 1'b0;
`endif

endmodule

// File: tb/tb_count_cmd_arbiter.sv
// Scoreboard bench for count_cmd_arbiter: model predicts per-cycle outputs, a monitor compares.
module tb_count_cmd_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic [15:0] sw = '0;
    logic        hold = 1'b0;
    logic [15:0] count;
    logic [3:0]  grant;
    logic [3:0]  pend;
    logic        drop;
    logic        sat;

    always #5 clk = ~clk;

    count_cmd_arbiter dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .sw    (sw),
        .hold  (hold),
        .count (count),
        .grant (grant),
        .pend  (pend),
        .drop  (drop),
        .sat   (sat)
    );

    typedef struct {
        int          cyc;
        logic [3:0]  grant;
        logic [3:0]  pend;
        logic [15:0] count;
        logic        drop;
        logic        sat;
    } exp_t;

    exp_t expq[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    bit   done = 0;

    // Reference state: reset values match the DUT after the first posedge with rst=1.
    bit   m_pend[4] = '{0, 0, 0, 0};
    int   m_ptr = 0;
    int   m_count = 0;
    bit   m_drop = 0;
    bit   m_sat = 0;

    task automatic chk(input string name, input int c, input logic [15:0] act,
                       input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", name, c, act, exp);
        end
    endtask

    // One clock of stimulus; the expectation for this cycle is pushed, then the model advances.
    task automatic step(input logic r, input logic [3:0] q, input logic [15:0] s,
                        input logic h);
        exp_t e;
        int   g;
        int   v;
        @(negedge clk);
        rst = r; req = q; sw = s; hold = h;
        g = -1;
        if (!h) begin
            for (int k = 0; k < 4; k++) begin
                if (g < 0 && m_pend[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
            end
        end
        e.cyc   = cyc;
        e.grant = (g < 0) ? 4'd0 : 4'(1 << g);
        e.pend  = '0;
        for (int i = 0; i < 4; i++) e.pend[i] = m_pend[i];
        e.count = 16'(m_count);
        e.drop  = m_drop;
        e.sat   = m_sat;
        expq.push_back(e);
        if (r) begin
            for (int i = 0; i < 4; i++) m_pend[i] = 0;
            m_ptr = 0; m_count = 0; m_drop = 0; m_sat = 0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (q[i] && m_pend[i] && g != i) m_drop = 1;
                m_pend[i] = q[i] || (m_pend[i] && g != i);
            end
            if (g >= 0) begin
                case (g)
                    0:       v = m_count + 1;
                    1:       v = m_count - 1;
                    2:       v = m_count - int'(s);
                    default: v = m_count + int'(s);
                endcase
`ifdef COUNT_SAT_EN
                if (v > 65535) begin v = 65535; m_sat = 1; end
                if (v < 0)     begin v = 0;     m_sat = 1; end
`else
                if (v > 65535) v = v - 65536;
                if (v < 0)     v = v + 65536;
`endif
                m_count = v;
                m_ptr   = (g + 1) % 4;
            end
        end
        cyc++;
    endtask

    task automatic idle(input int n, input logic [15:0] s, input logic h);
        for (int i = 0; i < n; i++) step(1'b0, 4'd0, s, h);
    endtask

    // Monitor: samples outputs 1 time unit after each falling edge, once inputs have settled.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (expq.size() != 0) begin
                e = expq.pop_front();
                chk("grant", e.cyc, {12'd0, grant}, {12'd0, e.grant});
                chk("pend",  e.cyc, {12'd0, pend},  {12'd0, e.pend});
                chk("count", e.cyc, count, e.count);
                chk("drop",  e.cyc, {15'd0, drop},  {15'd0, e.drop});
                chk("sat",   e.cyc, {15'd0, sat},   {15'd0, e.sat});
            end
            if (done && expq.size() == 0) break;
        end
    end

    initial begin : stimulus
        step(1'b1, 4'd0, 16'd0, 1'b0);
        step(1'b1, 4'd0, 16'd0, 1'b0);

        // Single request
        step(1'b0, 4'b0001, 16'd0, 1'b0);
        idle(3, 16'd0, 1'b0);

        // Four-way collision
        step(1'b1, 4'd0, 16'd5, 1'b0);
        step(1'b0, 4'b1111, 16'd5, 1'b0);
        idle(5, 16'd5, 1'b0);

        // Fairness between 0 and 3
        step(1'b1, 4'd0, 16'd7, 1'b0);
        for (int j = 0; j < 8; j++) step(1'b0, (j % 2 == 0) ? 4'b1001 : 4'b0000, 16'd7, 1'b0);
        idle(3, 16'd7, 1'b0);

        // Wrap / saturate below zero and above 0xFFFF
        step(1'b1, 4'd0, 16'd0, 1'b0);
        step(1'b0, 4'b0010, 16'd0, 1'b0);
        idle(2, 16'd0, 1'b0);
        step(1'b1, 4'd0, 16'd0, 1'b0);
        step(1'b0, 4'b1000, 16'hFFF0, 1'b0);
        idle(2, 16'hFFF0, 1'b0);
        step(1'b0, 4'b1000, 16'h0020, 1'b0);
        idle(2, 16'h0020, 1'b0);

        // Drop and hold, then release with sw=3
        step(1'b1, 4'd0, 16'd0, 1'b0);
        step(1'b0, 4'b0100, 16'd0, 1'b1);
        idle(2, 16'd0, 1'b1);
        step(1'b0, 4'b0100, 16'd0, 1'b1);
        idle(2, 16'd0, 1'b1);
        idle(4, 16'd3, 1'b0);

        // Reset mid-operation
        step(1'b1, 4'd0, 16'd0, 1'b0);
        step(1'b0, 4'b1111, 16'd9, 1'b0);
        step(1'b1, 4'd0, 16'd9, 1'b0);
        idle(4, 16'd9, 1'b0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic [3:0] q;
            for (int i = 0; i < 4; i++) q[i] = ($urandom % 3 == 0);
            step(($urandom % 250 == 0), q, 16'($urandom), ($urandom % 5 == 0));
        end
        idle(6, 16'd0, 1'b0);

        done = 1;
        repeat (3) @(negedge clk);
        chk("drain", cyc, 16'(expq.size()), 16'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/count_cmd_arbiter.md
# count_cmd_arbiter

Arbitrates four single-cycle count requests (up, down, subtract-switches, add-switches) onto one shared 16-bit counter register, so none are lost when they collide. It sits between the per-button synchronizer/one-shot stages and the LED output. It replaces ad-hoc fixed-priority update logic with pending-request capture, round-robin grant, a hold control, and drop/saturation status.

## Interface
- No parameters; width fixed at 16 bits, requester count fixed at 4.
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- req  in  4  one-cycle request pulses: [0] +1, [1] −1, [2] −sw, [3] +sw.
- sw  in  16  operand for req[2]/req[3]; sampled in the grant cycle.
- hold  in  1  when high, no grants are issued; requests still captured.
- count  out  16  shared counter value (registered).
- grant  out  4  one-hot, combinational from registered state; the request being serviced this cycle.
- pend  out  4  registered pending-request bits.
- drop  out  1  sticky: a request arrived while its pending bit was already set and not granted.
- sat  out  1  sticky saturation flag (constant 0 when the macro is absent).

## Operation
- Pending capture, per index i, at each edge:
  - pend[i] ← req[i] | (pend[i] & ~grant[i]).
  - If req[i] is high while grant[i] is also high, pend[i] stays 1 and the new request is kept.
  - If req[i] is high while pend[i]=1 and grant[i]=0, the request merges into the existing pending bit, is lost as a separate event, and drop ← 1.
- Arbiter, round-robin:
  - Pointer ptr[1:0] holds the highest-priority index.
  - Search indices ptr, ptr+1, ptr+2, ptr+3 (mod 4); grant the first with pend=1.
  - Grant only if hold=0 and at least one pend bit is set; otherwise grant=0.
  - On a grant to index g: ptr ← g+1 (mod 4). With no grant, ptr is unchanged.
- Datapath, applied at the edge ending the grant cycle:
  - g=0: count+1. g=1: count−1. g=2: count−sw. g=3: count+sw.
  - At most one update per cycle.
- Arithmetic is unsigned, 16-bit, and wraps modulo 2^16 by default.
- State encoding: pend, ptr, count, drop, sat. No separate FSM; the arbiter is effectively IDLE (pend=0 or hold=1) or SERVE (grant≠0) each cycle.
- Reset values: count=0x0000, pend=0, ptr=0, drop=0, sat=0, therefore grant=0.
- Reset mid-operation discards all pending requests. A req pulse coincident with rst is ignored.

## Timing
- req[i] pulse in cycle k → pend[i]=1 in cycle k+1 → earliest grant in cycle k+1 → count updated and visible in cycle k+2.
- Latency is 2 cycles for an uncontended request.
- Worst-case wait with hold=0 is 3 extra cycles, since all four indices may be pending.
- sw must be stable in the grant cycle only.
- hold rising takes effect in the same cycle: grant is 0 that cycle. Pending bits are retained.
- drop and sat clear only on rst.

## Configuration
- COUNT_SAT_EN defined:
  - Increments and additions clamp at 0xFFFF; decrements and subtractions clamp at 0x0000.
  - Any clamped update sets sat ← 1.
- COUNT_SAT_EN undefined:
  - Modulo-2^16 wrap.
  - sat is tied to 0.

## Test plan
- Single request: from reset, pulse req[0] in cycle 1 → grant=0001 in cycle 2, count=0x0001 in cycle 3; pend returns to 0.
- Four-way collision: sw=5, count=0, req=1111 for one cycle → grants 0,1,2,3 on four consecutive cycles; count sequence 1, 0, 0xFFFB, 0x0000; drop stays 0.
- Fairness:
  - Hold req[0] and req[3] pending with repeated pulses → grants alternate 0,3,0,3.
  - ptr advancement is verified after each grant.
- Wrap and saturate: count=0, pulse req[1].
  - Without macro → count=0xFFFF, sat=0.
  - With COUNT_SAT_EN → count=0x0000, sat=1.
  - Repeat with count=0xFFF0, sw=0x0020, req[3].
- Drop and hold:
  - hold=1, pulse req[2] twice, 3 cycles apart → pend=0100, drop=1, count unchanged.
  - Release hold with sw=3 → exactly one subtract, count=0xFFFD.
- Reset mid-operation: req=1111, assert rst in the next cycle → count=0, pend=0, grant=0, drop=0. No update occurs after rst deasserts.
